change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
Payout side of the vending controller. It takes a change or refund amount in half-yuan units and drives the coin hopper with one-cycle eject pulses, one coin at a time. After each pulse it waits for the hopper's coin-sense confirmation, retries on timeout, and reports done or fault. It sits between the coin-accept/vend FSM (the requester) and the two hopper actuators: one-yuan and half-yuan.

Parameters:
TIMEOUT, 16, cycles allowed from eject pulse to matching coin-sense before a retry
GAP_CYC, 4, idle cycles between a confirmed coin and the next selection (hopper settle)
MAX_RETRY, 2, eject attempts per coin before FAULT (attempt count includes the first)

Ports:
sys_clk  in  1  system clock, rising edge
sys_rst_n  in  1  asynchronous active-low reset
req  in  1  one-cycle request strobe; sampled only in IDLE
req_amt  in  4  amount to pay out, half-yuan units (0..15 = 0..7.5 yuan)
one_empty  in  1  one-yuan hopper empty (level)
half_empty  in  1  half-yuan hopper empty (level)
sense_one  in  1  one-cycle pulse, one-yuan coin passed exit sensor
sense_half  in  1  one-cycle pulse, half-yuan coin passed exit sensor
clr_fault  in  1  one-cycle strobe, leaves FAULT
eject_one  out  1  one-cycle eject pulse to one-yuan hopper
eject_half  out  1  one-cycle eject pulse to half-yuan hopper
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse on successful completion
fault  out  1  level, high while in FAULT
PRemain  out  4  amount still owed, half-yuan units

Behaviour:
- Reset (async, sys_rst_n=0): state IDLE; all outputs 0; PRemain=0; retry and timer counters 0. Reset mid-payout aborts immediately. No pulse completes and no done is issued.
- All outputs are registered.
- IDLE:
  - req=1 latches req_amt into PRemain.
  - If req_amt==0, go to DONE; otherwise go to SEL.
  - req in any other state is ignored.
- SEL, greedy coin choice:
  - PRemain>=2 and !one_empty: coin=ONE.
  - Otherwise, PRemain>=1 and !half_empty: coin=HALF.
  - Otherwise: FAULT. This covers remaining 1 with the half hopper empty, and both hoppers empty.
  - When the one-yuan hopper is empty, PRemain>=2 is paid in halves.
- EJECT: the chosen eject_* is high for exactly this cycle. Timer cleared, then WAIT_ACK.
- Latency: req sampled at edge k → SEL at k+1 → eject pulse high during cycle k+2.
- WAIT_ACK: timer increments each cycle.
  - Matching sense pulse: PRemain -= 2 (ONE) or 1 (HALF); retry cleared. Go to DONE if the new PRemain==0, else GAP.
  - Sense for the other coin type: FAULT. This is a misroute; PRemain is unchanged.
  - Timer reaches TIMEOUT-1 with no sense: retry+1. If retry==MAX_RETRY go to FAULT, else back to EJECT to re-pulse the same coin type.
  - Sense arriving on the same cycle as the timeout counts as success.
- GAP: waits GAP_CYC cycles, then SEL. Hopper-empty flags are re-evaluated in SEL.
- DONE: done=1 for one cycle, PRemain=0, then IDLE.
- FAULT:
  - fault=1 and busy=1. PRemain holds the unpaid amount for the host to read.
  - clr_fault → IDLE with PRemain cleared. clr_fault in any other state is ignored.
- Sense pulses outside WAIT_ACK are ignored.
- eject_one and eject_half are never high together.
- PRemain never underflows; the greedy rule guarantees this.
- Encoding: state is one-hot, with a default branch that returns to IDLE.

Decomposition:
- Shared package vending_pkg:
  - half-yuan unit definition and amount width (4).
  - coin-type constants COIN_HALF and COIN_ONE.
  - the one-hot state encodings for this block, alongside the existing vend FSM encodings.
- One sub-module: dispense_timer.
  - Width derived from TIMEOUT.
  - Inputs: clear, enable. Output: expired.
  - Reused for the GAP count by loading GAP_CYC.

Test Plan:
- Amount 3, both hoppers full: req_amt=3, sense_one 3 cycles after eject_one.
  - eject_one in cycle 2; PRemain 3→1; 4 GAP cycles.
  - Then eject_half; sense_half → PRemain 0; done pulses once; busy falls the next cycle.
- Zero amount: req_amt=0 → no eject pulse; done one cycle after req; busy high for exactly 1 cycle.
- One-yuan hopper empty: one_empty=1, req_amt=4 → four eject_half pulses, none on eject_one; PRemain 4→3→2→1→0; done.
- Timeout and retry: req_amt=2, no sense after the first eject_one → second eject_one exactly TIMEOUT cycles later.
  - Still no sense → fault=1, PRemain=2.
  - clr_fault → IDLE, PRemain=0, fault=0.
- Misroute and stray sense: sense_half during WAIT_ACK for ONE → FAULT, PRemain unchanged. A stray sense_one in IDLE has no effect.
- Reset mid-payout: assert sys_rst_n=0 during WAIT_ACK of amount 5 → all outputs 0 asynchronously; a later req_amt=1 completes normally.

Source files
------------

// File: rtl/vending_pkg.sv
// vending_pkg: shared amount/coin types and state encodings for the vending controller
package vending_pkg;
  localparam int AMT_W = 4;
  typedef logic [AMT_W-1:0] amt_t;
  typedef enum logic {COIN_HALF = 1'b0, COIN_ONE = 1'b1} coin_t;
  typedef enum logic [3:0] {
    V_IDLE   = 4'b0001,
    V_CREDIT = 4'b0010,
    V_VEND   = 4'b0100,
    V_CHANGE = 4'b1000
  } vend_state_t;
  typedef enum logic [6:0] {
    S_IDLE  = 7'b0000001,
    S_SEL   = 7'b0000010,
    S_EJECT = 7'b0000100,
    S_WAIT  = 7'b0001000,
    S_GAP   = 7'b0010000,
    S_DONE  = 7'b0100000,
    S_FAULT = 7'b1000000
  } disp_state_t;
  function automatic amt_t coin_value(coin_t c);
    return (c == COIN_ONE) ? amt_t'(2) : amt_t'(1);
  endfunction
endpackage

// File: rtl/dispense_timer.sv
// dispense_timer: up-counter with synchronous clear; expired while count equals last
// ports: clk, rst_n (async active-low), clear, enable, last (terminal count), expired
module dispense_timer #(
  parameter int TIMEOUT = 16,
  localparam int W = $clog2(TIMEOUT)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] last,
  output logic         expired
);
  logic [W-1:0] count_q, count_d;
  always_comb count_d = clear ? '0 : enable ? count_q + 1'b1 : count_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count_q <= '0;
    else count_q <= count_d;
  assign expired = count_q == last;
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays out an amount in half-yuan units one coin at a time with ack/retry
// ports: sys_clk, sys_rst_n (async active-low); req/req_amt request; one_empty/half_empty hopper levels;
//        sense_one/sense_half coin-exit pulses; clr_fault; eject_one/eject_half pulses; busy, done, fault, PRemain
module change_dispenser
  import vending_pkg::*;
#(
  parameter int TIMEOUT   = 16,
  parameter int GAP_CYC   = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             req,
  input  logic [AMT_W-1:0] req_amt,
  input  logic             one_empty,
  input  logic             half_empty,
  input  logic             sense_one,
  input  logic             sense_half,
  input  logic             clr_fault,
  output logic             eject_one,
  output logic             eject_half,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [AMT_W-1:0] PRemain
);
  localparam int TW = $clog2(TIMEOUT);
  localparam int RW = $clog2(MAX_RETRY + 1);
  disp_state_t state_q, state_d;
  coin_t coin_q, coin_d;
  amt_t premain_q, premain_d;
  logic [RW-1:0] retry_q, retry_d;
  logic eject_one_q, eject_one_d, eject_half_q, eject_half_d;
  logic busy_q, busy_d, done_q, done_d, fault_q, fault_d;
  logic tmr_clear, tmr_en, tmr_expired, sense_match, sense_miss;
  logic [TW-1:0] tmr_last;
  assign sense_match = (coin_q == COIN_ONE) ? sense_one : sense_half;
  assign sense_miss  = (coin_q == COIN_ONE) ? sense_half : sense_one;
  // The count runs across EJECT and WAIT_ACK so a re-pulse lands exactly TIMEOUT cycles after the last one.
  assign tmr_clear = (state_d != state_q) && (state_q != S_EJECT);
  assign tmr_en    = state_q inside {S_EJECT, S_WAIT, S_GAP};
  assign tmr_last  = (state_q == S_GAP) ? TW'(GAP_CYC - 1) : TW'(TIMEOUT - 1);
  dispense_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .last   (tmr_last),
    .expired(tmr_expired)
  );
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state_q      <= S_IDLE;
      coin_q       <= COIN_HALF;
      premain_q    <= '0;
      retry_q      <= '0;
      eject_one_q  <= 1'b0;
      eject_half_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      coin_q       <= coin_d;
      premain_q    <= premain_d;
      retry_q      <= retry_d;
      eject_one_q  <= eject_one_d;
      eject_half_q <= eject_half_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fault_q      <= fault_d;
    end
  always_comb begin
    state_d   = state_q;
    coin_d    = coin_q;
    premain_d = premain_q;
    retry_d   = retry_q;
    case (state_q)
      S_IDLE: if (req) begin
        premain_d = req_amt;
        state_d   = (req_amt == '0) ? S_DONE : S_SEL;
      end
      S_SEL: begin
        coin_d  = (premain_q >= amt_t'(2) && !one_empty) ? COIN_ONE : COIN_HALF;
        state_d = ((premain_q >= amt_t'(2) && !one_empty) || (premain_q != '0 && !half_empty)) ? S_EJECT : S_FAULT;
      end
      S_EJECT: state_d = S_WAIT;
      // A wrong-type sense wins over a simultaneous matching one: the hopper routing is suspect.
      S_WAIT: if (sense_miss) state_d = S_FAULT;
      else if (sense_match) begin
        premain_d = premain_q - coin_value(coin_q);
        retry_d   = '0;
        state_d   = (premain_d == '0) ? S_DONE : S_GAP;
      end else if (tmr_expired) begin
        retry_d = retry_q + 1'b1;
        state_d = (retry_d == RW'(MAX_RETRY)) ? S_FAULT : S_EJECT;
      end
      S_GAP: if (tmr_expired) state_d = S_SEL;
      S_DONE: begin
        premain_d = '0;
        state_d   = S_IDLE;
      end
      S_FAULT: if (clr_fault) begin
        premain_d = '0;
        retry_d   = '0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    eject_one_d  = (state_d == S_EJECT) && (coin_d == COIN_ONE);
    eject_half_d = (state_d == S_EJECT) && (coin_d == COIN_HALF);
    busy_d       = state_d != S_IDLE;
    done_d       = state_d == S_DONE;
    fault_d      = state_d == S_FAULT;
  end
  assign eject_one  = eject_one_q;
  assign eject_half = eject_half_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fault      = fault_q;
  assign PRemain    = premain_q;
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: scoreboard bench with a coin-level payout model and a reactive hopper driver
module tb_change_dispenser;
  localparam int TIMEOUT = 16, GAP_CYC = 4, MAX_RETRY = 2;
  localparam int EV_EJ_ONE = 0, EV_EJ_HALF = 1, EV_DONE = 2, EV_FAULT = 3, EV_CLR = 4;
  localparam int P_ACK = 0, P_DROP = 1, P_MIS = 2;
  typedef struct {int kind; int rem; int cyc;} ev_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req = 1'b0, one_empty = 1'b0, half_empty = 1'b0;
  logic sense_one = 1'b0, sense_half = 1'b0, clr_fault = 1'b0;
  logic [3:0] req_amt = '0;
  logic eject_one, eject_half, busy, done, fault;
  logic [3:0] PRemain;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  int p_kind[64], p_d[64];
  ev_t exp_q[$];
  change_dispenser #(.TIMEOUT(TIMEOUT), .GAP_CYC(GAP_CYC), .MAX_RETRY(MAX_RETRY)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .req(req), .req_amt(req_amt),
    .one_empty(one_empty), .half_empty(half_empty), .sense_one(sense_one), .sense_half(sense_half),
    .clr_fault(clr_fault), .eject_one(eject_one), .eject_half(eject_half), .busy(busy),
    .done(done), .fault(fault), .PRemain(PRemain)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic push(input int kind, input int rem, input int c);
    exp_q.push_back('{kind, rem, c});
  endtask
  // Reference model: walks the payout coin by coin from the greedy rule and the
  // per-eject hopper plan, producing every observable event with its absolute cycle.
  task automatic model(input int amt, input bit oe, input bit he, input int r);
    int rem, t, k, att, coin, pk, pd;
    rem = amt; t = r + 1; k = 0;
    if (amt == 0) begin push(EV_DONE, 0, r + 1); return; end
    forever begin
      if (rem >= 2 && !oe) coin = 2;
      else if (!he) coin = 1;
      else begin push(EV_FAULT, rem, t + 1); return; end
      t = t + 1; att = 0;
      forever begin
        push(coin == 2 ? EV_EJ_ONE : EV_EJ_HALF, rem, t);
        pk = (k < 64) ? p_kind[k] : P_DROP;
        pd = (k < 64) ? p_d[k] : 1;
        k++;
        if (pk == P_ACK) begin
          rem -= coin;
          if (rem == 0) begin push(EV_DONE, 0, t + pd + 1); return; end
          t = t + pd + 1 + GAP_CYC;
          break;
        end
        if (pk == P_MIS) begin push(EV_FAULT, rem, t + pd + 1); return; end
        att++;
        if (att == MAX_RETRY) begin push(EV_FAULT, rem, t + TIMEOUT); return; end
        t += TIMEOUT;
      end
    end
  endtask
  task automatic set_plan(input int kind, input int d);
    for (int i = 0; i < 64; i++) begin p_kind[i] = kind; p_d[i] = d; end
  endtask
  task automatic rand_plan();
    for (int i = 0; i < 64; i++) begin
      int r;
      r = $urandom_range(0, 99);
      p_kind[i] = (r < 82) ? P_ACK : (r < 92) ? P_DROP : P_MIS;
      p_d[i] = $urandom_range(1, TIMEOUT - 1);
    end
  endtask
  task automatic do_reset();
    #2 rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic run_txn(input int amt, input bit oe, input bit he);
    int k, s_cyc, pk, w;
    bit s_one, fin;
    k = 0; s_cyc = -1; s_one = 1'b0; fin = 1'b0;
    @(negedge clk);
    one_empty = oe; half_empty = he;
    @(negedge clk);
    req = 1'b1; req_amt = 4'(amt);
    model(amt, oe, he, cyc);
    @(negedge clk);
    req = 1'b0;
    for (int n = 0; n < 600 && !fin; n++) begin
      sense_one = 1'b0; sense_half = 1'b0;
      if (cyc == s_cyc) begin sense_one = s_one; sense_half = !s_one; end
      if (eject_one || eject_half) begin
        pk = (k < 64) ? p_kind[k] : P_DROP;
        if (pk != P_DROP) begin
          s_cyc = cyc + p_d[k];
          s_one = (pk == P_ACK) == eject_one;
        end
        k++;
      end
      if (done) fin = 1'b1;
      else if (fault) begin
        w = $urandom_range(1, 4);
        req = 1'b1; req_amt = 4'd7;
        @(negedge clk);
        req = 1'b0;
        repeat (w) @(negedge clk);
        clr_fault = 1'b1;
        push(EV_CLR, 0, cyc + 1);
        @(negedge clk);
        clr_fault = 1'b0;
        fin = 1'b1;
      end
      if (!fin) @(negedge clk);
    end
    sense_one = 1'b0; sense_half = 1'b0;
    if (!fin) begin
      check("txn_complete", 0, 1);
      do_reset();
    end
  endtask
  task automatic observe(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin check("unexpected_event", kind, -1); return; end
    e = exp_q.pop_front();
    check("event_kind", kind, e.kind);
    check("event_cycle", cyc, e.cyc);
    check("premain", int'(PRemain), e.rem);
    check("busy", int'(busy), int'(kind != EV_CLR));
  endtask
  initial begin : monitor
    bit fprev, chk_idle;
    fprev = 1'b0; chk_idle = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        fprev = 1'b0; chk_idle = 1'b0;
      end else begin
        if (chk_idle) check("busy_after_done", int'(busy), 0);
        chk_idle = done;
        if (eject_one || eject_half) check("eject_exclusive", int'(eject_one & eject_half), 0);
        if (eject_one) observe(EV_EJ_ONE);
        if (eject_half) observe(EV_EJ_HALF);
        if (done) observe(EV_DONE);
        if (fault && !fprev) observe(EV_FAULT);
        if (!fault && fprev) observe(EV_CLR);
        fprev = fault;
      end
    end
  end
  initial begin
    repeat (3) @(negedge clk);
    check("rst_eject_one", int'(eject_one), 0);
    check("rst_eject_half", int'(eject_half), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_fault", int'(fault), 0);
    check("rst_premain", int'(PRemain), 0);
    rst_n = 1'b1;
    set_plan(P_ACK, 3);
    run_txn(3, 0, 0);
    run_txn(0, 0, 0);
    set_plan(P_ACK, 2);
    run_txn(4, 1, 0);
    set_plan(P_DROP, 1);
    run_txn(2, 0, 0);
    set_plan(P_ACK, 4);
    p_kind[0] = P_MIS;
    run_txn(2, 0, 0);
    @(negedge clk);
    sense_one = 1'b1;
    @(negedge clk);
    sense_one = 1'b0; sense_half = 1'b1;
    @(negedge clk);
    sense_half = 1'b0;
    repeat (2) @(negedge clk);
    check("stray_busy", int'(busy), 0);
    check("stray_premain", int'(PRemain), 0);
    set_plan(P_ACK, TIMEOUT - 1);
    run_txn(1, 0, 0);
    set_plan(P_ACK, 2);
    run_txn(3, 1, 1);
    run_txn(1, 0, 1);
    run_txn(3, 0, 1);
    p_kind[0] = P_DROP;
    run_txn(5, 0, 0);
    set_plan(P_ACK, 10);
    @(negedge clk);
    one_empty = 1'b0; half_empty = 1'b0;
    @(negedge clk);
    req = 1'b1; req_amt = 4'd5;
    model(5, 0, 0, cyc);
    @(negedge clk);
    req = 1'b0;
    for (int n = 0; n < 10 && !eject_one; n++) @(negedge clk);
    check("abort_first_eject", int'(eject_one), 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("abort_eject_one", int'(eject_one), 0);
    check("abort_eject_half", int'(eject_half), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_fault", int'(fault), 0);
    check("abort_premain", int'(PRemain), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    set_plan(P_ACK, 5);
    run_txn(1, 0, 0);
    for (int i = 0; i < 70; i++) begin
      rand_plan();
      run_txn($urandom_range(0, 15), $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clk);
        if ($urandom_range(0, 1) == 1) sense_one = 1'b1; else sense_half = 1'b1;
        @(negedge clk);
        sense_one = 1'b0; sense_half = 1'b0;
      end
    end
    repeat (5) @(negedge clk);
    check("leftover_expected", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
